cpu_decode: RTL and testbench

Instruction decode stage of the Rv32H core. It sits directly downstream of the fetch stage. Each fetch completion pulse delivers an instruction word and its PC. The block buffers up to two raw words, decodes RV32I fields into a registered output slot, and presents them to execute through a valid/ready handshake. Fetch has no back-pressure input, so the buffer absorbs execute stalls and flags overflow.

---
 rtl/cpu_pkg.sv | 94 +++++++++
 rtl/cpu_decode_if.sv | 37 +++
 rtl/cpu_decode_fifo.sv | 60 ++++++
 rtl/cpu_decode.sv | 82 ++++++++
 tb/tb_cpu_decode.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared RV32I decode definitions for the Rv32H decode stage.
//   - OPC_* : 7-bit major opcode constants
//   - op_t  : 4-bit op class; ILLEGAL is the all-zero encoding so reset yields it
//   - imm_fmt_t : immediate format selector
//   - decode_op / imm_fmt_of / decode_imm : pure combinational helpers
package cpu_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        OP_ILLEGAL = 4'd0,
        OP_LUI     = 4'd1,
        OP_AUIPC   = 4'd2,
        OP_JAL     = 4'd3,
        OP_JALR    = 4'd4,
        OP_BRANCH  = 4'd5,
        OP_LOAD    = 4'd6,
        OP_STORE   = 4'd7,
        OP_OP_IMM  = 4'd8,
        OP_OP      = 4'd9,
        OP_FENCE   = 4'd10,
        OP_SYSTEM  = 4'd11
    } op_t;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_t;

    // Compressed-space words (bits [1:0] != 2'b11) are never RV32I.
    function automatic op_t decode_op(input logic [31:0] instr);
        op_t op;
        op = OP_ILLEGAL;
        if (instr[1:0] == 2'b11) begin
            case (instr[6:0])
                OPC_LUI:    op = OP_LUI;
                OPC_AUIPC:  op = OP_AUIPC;
                OPC_JAL:    op = OP_JAL;
                OPC_JALR:   op = OP_JALR;
                OPC_BRANCH: op = OP_BRANCH;
                OPC_LOAD:   op = OP_LOAD;
                OPC_STORE:  op = OP_STORE;
                OPC_OP_IMM: op = OP_OP_IMM;
                OPC_OP:     op = OP_OP;
                OPC_FENCE:  op = OP_FENCE;
                OPC_SYSTEM: op = OP_SYSTEM;
                default:    op = OP_ILLEGAL;
            endcase
        end
        return op;
    endfunction

    function automatic imm_fmt_t imm_fmt_of(input op_t op);
        imm_fmt_t fmt;
        case (op)
            OP_JALR, OP_LOAD, OP_OP_IMM, OP_SYSTEM: fmt = IMM_I;
            OP_STORE:                               fmt = IMM_S;
            OP_BRANCH:                              fmt = IMM_B;
            OP_LUI, OP_AUIPC:                       fmt = IMM_U;
            OP_JAL:                                 fmt = IMM_J;
            default:                                fmt = IMM_NONE;
        endcase
        return fmt;
    endfunction

    function automatic logic [31:0] decode_imm(input logic [31:0] instr, input imm_fmt_t fmt);
        logic [31:0] imm;
        case (fmt)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21],
                            1'b0};
            default: imm = 32'd0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/cpu_decode_if.sv
// cpu_decode_if: fetch-side inputs and execute-side valid/ready slot of the decode stage.
//   slave  : decode stage view (fetch/ready in, decoded slot out)
//   master : surrounding pipeline view
interface cpu_decode_if;
    import cpu_pkg::*;

    logic        i_fetched;
    logic [31:0] i_instruction;
    logic [31:0] i_pc;
    logic        i_ready;

    logic        o_valid;
    logic [31:0] o_pc;
    logic [31:0] o_instruction;
    op_t         o_op;
    logic [4:0]  o_rd;
    logic [4:0]  o_rs1;
    logic [4:0]  o_rs2;
    logic [2:0]  o_funct3;
    logic        o_funct7b5;
    logic [31:0] o_imm;
    logic        o_illegal;
    logic        o_overflow;

    modport slave (
        input  i_fetched, i_instruction, i_pc, i_ready,
        output o_valid, o_pc, o_instruction, o_op, o_rd, o_rs1, o_rs2, o_funct3,
               o_funct7b5, o_imm, o_illegal, o_overflow
    );

    modport master (
        output i_fetched, i_instruction, i_pc, i_ready,
        input  o_valid, o_pc, o_instruction, o_op, o_rd, o_rs1, o_rs2, o_funct3,
               o_funct7b5, o_imm, o_illegal, o_overflow
    );

endinterface

// File: rtl/cpu_decode_fifo.sv
// cpu_decode_fifo: 2-entry, 64-bit FIFO holding {pc, instruction} from fetch.
//   i_clock, i_reset : clock, async active-high reset (empties the FIFO)
//   i_push, i_data   : write request and data; ignored when full unless popping too
//   i_pop            : read request; ignored when empty
//   o_data           : head entry (valid when !o_empty)
//   o_empty, o_full  : occupancy flags
module cpu_decode_fifo (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_push,
    input  logic        i_pop,
    input  logic [63:0] i_data,
    output logic [63:0] o_data,
    output logic        o_empty,
    output logic        o_full
);

    logic [63:0] mem_q [2];
    logic        wr_ptr_q;
    logic        rd_ptr_q;
    logic [1:0]  count_q;
    logic        do_push;
    logic        do_pop;

    assign o_empty = (count_q == 2'd0);
    assign o_full  = (count_q == 2'd2);
    assign o_data  = mem_q[rd_ptr_q];

    // A push into a full FIFO is accepted only when the head leaves on the same edge.
    assign do_push = i_push && (!o_full || i_pop);
    assign do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge i_clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

endmodule

// File: rtl/cpu_decode.sv
// cpu_decode: RV32I decode stage.
//   i_clock, i_reset : clock, async active-high reset (clears FIFO and all outputs)
//   bus (slave)      : fetch pulse {i_fetched, i_instruction, i_pc}, execute handshake
//                      {o_valid, i_ready}, registered decoded fields and sticky o_overflow
// Fetch words are buffered in a 2-entry FIFO; the head is decoded combinationally and
// captured into the output slot whenever the slot is free.
module cpu_decode
    import cpu_pkg::*;
(
    input  logic   i_clock,
    input  logic   i_reset,
    cpu_decode_if.slave bus
);

    logic        slot_free;
    logic        fifo_pop;
    logic        fifo_empty;
    logic        fifo_full;
    logic [63:0] fifo_head;
    logic [31:0] head_pc;
    logic [31:0] head_instr;
    op_t         head_op;
    logic [31:0] head_imm;

    // Slot can take a new entry if empty or being handed off this edge.
    assign slot_free = !bus.o_valid || bus.i_ready;
    assign fifo_pop  = slot_free && !fifo_empty;

    cpu_decode_fifo u_fifo (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_push  (bus.i_fetched),
        .i_pop   (fifo_pop),
        .i_data  ({bus.i_pc, bus.i_instruction}),
        .o_data  (fifo_head),
        .o_empty (fifo_empty),
        .o_full  (fifo_full)
    );

    assign head_pc    = fifo_head[63:32];
    assign head_instr = fifo_head[31:0];
    assign head_op    = decode_op(head_instr);
    assign head_imm   = decode_imm(head_instr, imm_fmt_of(head_op));

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            bus.o_valid       <= 1'b0;
            bus.o_pc          <= 32'd0;
            bus.o_instruction <= 32'd0;
            bus.o_op          <= OP_ILLEGAL;
            bus.o_rd          <= 5'd0;
            bus.o_rs1         <= 5'd0;
            bus.o_rs2         <= 5'd0;
            bus.o_funct3      <= 3'd0;
            bus.o_funct7b5    <= 1'b0;
            bus.o_imm         <= 32'd0;
            bus.o_illegal     <= 1'b0;
            bus.o_overflow    <= 1'b0;
        end else begin
            // Dropped word: FIFO full and the head is not leaving this edge.
            if (bus.i_fetched && fifo_full && !fifo_pop) begin
                bus.o_overflow <= 1'b1;
            end
            if (slot_free) begin
                bus.o_valid <= !fifo_empty;
                if (!fifo_empty) begin
                    bus.o_pc          <= head_pc;
                    bus.o_instruction <= head_instr;
                    bus.o_op          <= head_op;
                    bus.o_rd          <= head_instr[11:7];
                    bus.o_rs1         <= head_instr[19:15];
                    bus.o_rs2         <= head_instr[24:20];
                    bus.o_funct3      <= head_instr[14:12];
                    bus.o_funct7b5    <= head_instr[30];
                    bus.o_imm         <= head_imm;
                    bus.o_illegal     <= (head_op == OP_ILLEGAL);
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_decode.sv
// Scoreboard bench for cpu_decode: the stimulus process pushes hand-computed expected
// slots into a queue; the monitor pops and compares on every handshake transfer.
module tb_cpu_decode;
    import cpu_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic        f7b5;
        logic [31:0] imm;
        logic        illegal;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    logic clk = 1'b0;
    logic rst = 1'b0;

    cpu_decode_if dif();

    cpu_decode u_dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (dif.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, expv);
        end
    endtask

    // Hand-decoded reference vectors.
    function automatic exp_t vec(input int k, input logic [31:0] pc);
        exp_t e;
        e.pc = pc;
        case (k)
            // addi x1,x0,5
            0: begin e.instr = 32'h00500093; e.op = 4'd8; e.rd = 5'd1; e.rs1 = 5'd0;
                     e.rs2 = 5'd5; e.f3 = 3'd0; e.f7b5 = 1'b0; e.imm = 32'h00000005;
                     e.illegal = 1'b0; end
            // sw x2,-4(x1)
            1: begin e.instr = 32'hFE20AE23; e.op = 4'd7; e.rd = 5'd28; e.rs1 = 5'd1;
                     e.rs2 = 5'd2; e.f3 = 3'd2; e.f7b5 = 1'b1; e.imm = 32'hFFFFFFFC;
                     e.illegal = 1'b0; end
            // lui x5,0x12345
            2: begin e.instr = 32'h123452B7; e.op = 4'd1; e.rd = 5'd5; e.rs1 = 5'd8;
                     e.rs2 = 5'd3; e.f3 = 3'd5; e.f7b5 = 1'b0; e.imm = 32'h12345000;
                     e.illegal = 1'b0; end
            // beq x0,x0,-4
            3: begin e.instr = 32'hFE000EE3; e.op = 4'd5; e.rd = 5'd29; e.rs1 = 5'd0;
                     e.rs2 = 5'd0; e.f3 = 3'd0; e.f7b5 = 1'b1; e.imm = 32'hFFFFFFFC;
                     e.illegal = 1'b0; end
            // jal x1,8
            4: begin e.instr = 32'h008000EF; e.op = 4'd3; e.rd = 5'd1; e.rs1 = 5'd0;
                     e.rs2 = 5'd8; e.f3 = 3'd0; e.f7b5 = 1'b0; e.imm = 32'h00000008;
                     e.illegal = 1'b0; end
            // all-zero word: illegal
            default: begin e.instr = 32'h00000000; e.op = 4'd0; e.rd = 5'd0; e.rs1 = 5'd0;
                     e.rs2 = 5'd0; e.f3 = 3'd0; e.f7b5 = 1'b0; e.imm = 32'h00000000;
                     e.illegal = 1'b1; end
        endcase
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle fetch pulse; expected result queued unless the word should be lost.
    task automatic push(input int k, input logic [31:0] pc, input bit expect_out);
        exp_t e;
        e = vec(k, pc);
        dif.i_instruction = e.instr;
        dif.i_pc          = pc;
        dif.i_fetched     = 1'b1;
        if (expect_out) exp_q.push_back(e);
        tick();
        dif.i_fetched = 1'b0;
    endtask

    // Monitor: a transfer happens on the next rising edge when valid && ready.
    always @(negedge clk) begin
        if (!rst && dif.o_valid && dif.i_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_slot: got pc %h, want no transfer", dif.o_pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("slot_pc", dif.o_pc, e.pc);
                check("slot_instr", dif.o_instruction, e.instr);
                check("slot_op", 32'(dif.o_op), 32'(e.op));
                check("slot_rd", 32'(dif.o_rd), 32'(e.rd));
                check("slot_rs1", 32'(dif.o_rs1), 32'(e.rs1));
                check("slot_rs2", 32'(dif.o_rs2), 32'(e.rs2));
                check("slot_funct3", 32'(dif.o_funct3), 32'(e.f3));
                check("slot_funct7b5", 32'(dif.o_funct7b5), 32'(e.f7b5));
                check("slot_imm", dif.o_imm, e.imm);
                check("slot_illegal", 32'(dif.o_illegal), 32'(e.illegal));
            end
        end
    end

    task automatic check_cleared(input string tag);
        check({tag, "_valid"}, 32'(dif.o_valid), 32'd0);
        check({tag, "_pc"}, dif.o_pc, 32'd0);
        check({tag, "_instr"}, dif.o_instruction, 32'd0);
        check({tag, "_op"}, 32'(dif.o_op), 32'd0);
        check({tag, "_rd"}, 32'(dif.o_rd), 32'd0);
        check({tag, "_imm"}, dif.o_imm, 32'd0);
        check({tag, "_illegal"}, 32'(dif.o_illegal), 32'd0);
        check({tag, "_overflow"}, 32'(dif.o_overflow), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        dif.i_fetched     = 1'b0;
        dif.i_instruction = 32'd0;
        dif.i_pc          = 32'd0;
        dif.i_ready       = 1'b0;
        #1 rst = 1'b1;
        #1 check_cleared("reset");
        tick();
        tick();
        rst = 1'b0;

        // Basic decode and 2-edge latency.
        dif.i_ready = 1'b1;
        push(0, 32'h0, 1'b1);
        check("lat_after_e0", 32'(dif.o_valid), 32'd0);
        tick();
        check("lat_after_e1", 32'(dif.o_valid), 32'd1);
        tick();
        check("idle_after_xfer", 32'(dif.o_valid), 32'd0);

        // Back-to-back formats at full throughput, then an illegal word.
        push(1, 32'h4, 1'b1);
        push(2, 32'h8, 1'b1);
        push(3, 32'hC, 1'b1);
        push(4, 32'h10, 1'b1);
        push(5, 32'h14, 1'b1);
        repeat (3) tick();
        check("drain_formats", exp_q.size(), 0);

        // Back-pressure: three words fill slot + FIFO without overflow.
        dif.i_ready = 1'b0;
        push(0, 32'h0, 1'b1);
        push(0, 32'h4, 1'b1);
        push(0, 32'h8, 1'b1);
        check("bp_hold_pc0", dif.o_pc, 32'h0);
        tick();
        tick();
        check("bp_hold_pc1", dif.o_pc, 32'h0);
        check("bp_hold_valid", 32'(dif.o_valid), 32'd1);
        check("bp_no_overflow", 32'(dif.o_overflow), 32'd0);
        // Push into the full FIFO on the same edge the head is popped.
        exp_q.push_back(vec(0, 32'h10));
        dif.i_instruction = 32'h00500093;
        dif.i_pc          = 32'h10;
        dif.i_fetched     = 1'b1;
        dif.i_ready       = 1'b1;
        check("bp_order0", dif.o_pc, 32'h0);
        tick();
        dif.i_fetched = 1'b0;
        check("bp_order1", dif.o_pc, 32'h4);
        tick();
        check("bp_order2", dif.o_pc, 32'h8);
        tick();
        check("bp_order3", dif.o_pc, 32'h10);
        tick();
        check("bp_empty", 32'(dif.o_valid), 32'd0);
        check("bp_full_pushpop_no_drop", 32'(dif.o_overflow), 32'd0);

        // Overflow: fourth word is dropped and the flag is sticky.
        dif.i_ready = 1'b0;
        push(0, 32'h0, 1'b1);
        push(0, 32'h4, 1'b1);
        push(0, 32'h8, 1'b1);
        check("ovf_before_drop", 32'(dif.o_overflow), 32'd0);
        push(0, 32'hC, 1'b0);
        check("ovf_set", 32'(dif.o_overflow), 32'd1);
        check("ovf_hold_pc", dif.o_pc, 32'h0);
        dif.i_ready = 1'b1;
        repeat (5) tick();
        check("ovf_drained_valid", 32'(dif.o_valid), 32'd0);
        check("ovf_sticky", 32'(dif.o_overflow), 32'd1);
        check("ovf_drain", exp_q.size(), 0);

        // Asynchronous reset between edges with FIFO full and slot valid.
        dif.i_ready = 1'b0;
        push(2, 32'h40, 1'b0);
        push(2, 32'h44, 1'b0);
        push(2, 32'h48, 1'b0);
        check("pre_reset_valid", 32'(dif.o_valid), 32'd1);
        #2 rst = 1'b1;
        #1 check_cleared("async_reset");
        tick();
        rst = 1'b0;
        dif.i_ready = 1'b1;
        push(1, 32'h80, 1'b1);
        check("post_reset_lat_e0", 32'(dif.o_valid), 32'd0);
        tick();
        check("post_reset_lat_e1", 32'(dif.o_valid), 32'd1);
        tick();
        tick();
        check("final_drain", exp_q.size(), 0);
        check("final_idle", 32'(dif.o_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
